// File: rtl/lsu_pkg.sv
// Shared types for the LSU bus master: funct3 codes, FSM states, legality check.
// The optional LSU_SW_FASTPATH_EN build lets aligned SW skip the read cycle.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  function automatic logic f3_illegal(
    input logic       wr,
    input logic [2:0] f3
  );
    logic ill;
    ill = 1'b1;
    case (f3)
      F3_B, F3_H, F3_W: ill = 1'b0;
      F3_BU, F3_HU:     ill = wr;
      default:          ill = 1'b1;
    endcase
    return ill;
  endfunction

endpackage

// File: rtl/lsu_bus_master_if.sv
// Pipeline request/response plus word bus, bundled for the LSU.
// master = the LSU itself, slave = pipeline and bus responders.
interface lsu_bus_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_misaligned;
  logic              resp_fault;
  logic [ADDR_W-1:0] bus_address;
  logic [DATA_W-1:0] bus_write_data;
  logic              bus_write_sig;
  logic [DATA_W-1:0] bus_read_data;
  logic              bus_selected;

  modport master (
    input  req_valid, req_write, req_funct3,
    input  req_addr, req_wdata,
    input  bus_read_data, bus_selected,
    output req_ready,
    output resp_valid, resp_rdata,
    output resp_misaligned, resp_fault,
    output bus_address, bus_write_data,
    output bus_write_sig
  );

  modport slave (
    output req_valid, req_write, req_funct3,
    output req_addr, req_wdata,
    output bus_read_data, bus_selected,
    input  req_ready,
    input  resp_valid, resp_rdata,
    input  resp_misaligned, resp_fault,
    input  bus_address, bus_write_data,
    input  bus_write_sig
  );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane logic: load extraction, store merge, misalign detection.
// Purely combinational.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  off,
  input  logic [2:0]  f3,
  output logic [31:0] rdata,
  output logic [31:0] merged,
  output logic        misaligned
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word[{off, 3'b000} +: 8];
    half_v = off[1] ? word[31:16] : word[15:0];

    rdata = word;
    case (f3)
      F3_B:    rdata = {{24{byte_v[7]}}, byte_v};
      F3_BU:   rdata = {24'd0, byte_v};
      F3_H:    rdata = {{16{half_v[15]}}, half_v};
      F3_HU:   rdata = {16'd0, half_v};
      default: rdata = word;
    endcase

    merged = wdata;
    case (f3)
      F3_B: begin
        merged = word;
        merged[{off, 3'b000} +: 8] = wdata[7:0];
      end
      F3_H: begin
        merged = word;
        if (off[1]) merged[31:16] = wdata[15:0];
        else        merged[15:0]  = wdata[15:0];
      end
      default: merged = wdata;
    endcase

    misaligned = 1'b0;
    unique case (1'b1)
      (f3 == F3_H || f3 == F3_HU): misaligned = off[0];
      (f3 == F3_W):                misaligned = |off;
      default:                     misaligned = 1'b0;
    endcase
  end

endmodule

// File: rtl/lsu_bus_master.sv
// LSU bus initiator: RV32I loads/stores as word bus cycles, RMW for sub-word.
// `define LSU_SW_FASTPATH_EN sends aligned SW straight to WR.
module lsu_bus_master
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic clk,
  input logic rst_n,
  lsu_bus_master_if.master lsu
);

  state_t            state;
  logic              c_write;
  logic [2:0]        c_f3;
  logic [1:0]        c_off;
  logic [DATA_W-1:0] c_wdata;

  logic              idle;
  logic [1:0]        off_sel;
  logic [2:0]        f3_sel;
  logic [31:0]       wdata_sel;
  logic [31:0]       rdata_ext;
  logic [31:0]       merged;
  logic              mis;
  logic [ADDR_W-1:0] word_addr;

  // In IDLE the aligner looks at the live request, afterwards at the capture.
  assign idle      = (state == IDLE);
  assign off_sel   = idle ? lsu.req_addr[1:0] : c_off;
  assign f3_sel    = idle ? lsu.req_funct3    : c_f3;
  assign wdata_sel = idle ? lsu.req_wdata     : c_wdata;
  assign word_addr = {lsu.req_addr[ADDR_W-1:2], 2'b00};

  lsu_align u_align (
    .word       (lsu.bus_read_data),
    .wdata      (wdata_sel),
    .off        (off_sel),
    .f3         (f3_sel),
    .rdata      (rdata_ext),
    .merged     (merged),
    .misaligned (mis)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      c_write             <= 1'b0;
      c_f3                <= '0;
      c_off               <= '0;
      c_wdata             <= '0;
      lsu.req_ready       <= 1'b1;
      lsu.resp_valid      <= 1'b0;
      lsu.resp_rdata      <= '0;
      lsu.resp_misaligned <= 1'b0;
      lsu.resp_fault      <= 1'b0;
      lsu.bus_address     <= '0;
      lsu.bus_write_data  <= '0;
      lsu.bus_write_sig   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (lsu.req_valid) begin
            c_write       <= lsu.req_write;
            c_f3          <= lsu.req_funct3;
            c_off         <= lsu.req_addr[1:0];
            c_wdata       <= lsu.req_wdata;
            lsu.req_ready <= 1'b0;
            if (f3_illegal(lsu.req_write, lsu.req_funct3)) begin
              state          <= RESP;
              lsu.resp_valid <= 1'b1;
              lsu.resp_fault <= 1'b1;
            end else if (mis) begin
              state               <= RESP;
              lsu.resp_valid      <= 1'b1;
              lsu.resp_misaligned <= 1'b1;
`ifdef LSU_SW_FASTPATH_EN
            end else if (lsu.req_write &&
                         lsu.req_funct3 == F3_W) begin
              state              <= WR;
              lsu.bus_address    <= word_addr;
              lsu.bus_write_data <= merged;
              lsu.bus_write_sig  <= 1'b1;
`endif
            end else begin
              state           <= RD;
              lsu.bus_address <= word_addr;
            end
          end
        end
        RD: begin
          if (!lsu.bus_selected) begin
            state           <= RESP;
            lsu.resp_valid  <= 1'b1;
            lsu.resp_fault  <= 1'b1;
            lsu.bus_address <= '0;
          end else if (c_write) begin
            state              <= WR;
            lsu.bus_write_data <= merged;
            lsu.bus_write_sig  <= 1'b1;
          end else begin
            state           <= RESP;
            lsu.resp_valid  <= 1'b1;
            lsu.resp_rdata  <= rdata_ext;
            lsu.bus_address <= '0;
          end
        end
        WR: begin
          state              <= RESP;
          lsu.resp_valid     <= 1'b1;
`ifdef LSU_SW_FASTPATH_EN
          lsu.resp_fault     <= !lsu.bus_selected;
`endif
          lsu.bus_address    <= '0;
          lsu.bus_write_data <= '0;
          lsu.bus_write_sig  <= 1'b0;
        end
        RESP: begin
          state               <= IDLE;
          lsu.req_ready       <= 1'b1;
          lsu.resp_valid      <= 1'b0;
          lsu.resp_rdata      <= '0;
          lsu.resp_misaligned <= 1'b0;
          lsu.resp_fault      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_bus_master.sv
// Scoreboard bench for lsu_bus_master with a small word memory at 0x8xxxxxxx.
// Expected responses are queued at issue and checked by a resp monitor.
module tb_lsu_bus_master;
  import lsu_pkg::*;

`ifdef LSU_SW_FASTPATH_EN
  localparam int SW_LAT = 2;
`else
  localparam int SW_LAT = 3;
`endif

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        mis;
    logic        fault;
    int          lat;
    int          t0;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_bus_master_if ifc ();

  lsu_bus_master dut (
    .clk   (clk),
    .rst_n (rst_n),
    .lsu   (ifc)
  );

  logic [31:0] mem [0:63];
  logic        poke_en = 1'b0;
  logic [5:0]  poke_idx = '0;
  logic [31:0] poke_val = '0;
  int          cyc = 0;
  int          wr_count = 0;
  logic [31:0] last_wdata = '0;
  int          addr_nz = 0;
  logic [31:0] last_addr = '0;
  int          checks = 0;
  int          failures = 0;
  exp_t        sbq [$];

  // Responder: combinational read, word write on clk.
  assign ifc.bus_selected  = (ifc.bus_address[31:28] == 4'h8);
  assign ifc.bus_read_data = mem[ifc.bus_address[7:2]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (poke_en) mem[poke_idx] <= poke_val;
    if (ifc.bus_write_sig) begin
      wr_count   <= wr_count + 1;
      last_wdata <= ifc.bus_write_data;
      if (ifc.bus_selected)
        mem[ifc.bus_address[7:2]] <= ifc.bus_write_data;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (ifc.bus_address != '0) begin
        addr_nz++;
        last_addr = ifc.bus_address;
        chk("addr_align", {30'd0, ifc.bus_address[1:0]}, 32'd0);
      end
      if (ifc.resp_valid) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_resp: got resp_valid=1 expected 0");
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk({e.name, ".rdata"}, ifc.resp_rdata, e.rdata);
          chk({e.name, ".mis"}, {31'd0, ifc.resp_misaligned}, {31'd0, e.mis});
          chk({e.name, ".fault"}, {31'd0, ifc.resp_fault}, {31'd0, e.fault});
          chk({e.name, ".lat"}, cyc - e.t0, e.lat);
          chk({e.name, ".bus_idle"},
              {31'd0, ifc.bus_write_sig} | ifc.bus_address, 32'd0);
        end
      end
    end
  end

  task automatic poke(input logic [5:0] idx, input logic [31:0] v);
    @(negedge clk);
    poke_en  = 1'b1;
    poke_idx = idx;
    poke_val = v;
    @(negedge clk);
    poke_en  = 1'b0;
  endtask

  task automatic access(input string nm, input logic w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] er, input logic em,
                        input logic ef, input int lat);
    exp_t e;
    bit   done;
    @(negedge clk);
    for (int i = 0; i < 20 && !ifc.req_ready; i++) @(negedge clk);
    e.name = nm; e.rdata = er; e.mis = em; e.fault = ef;
    e.lat = lat; e.t0 = cyc;
    sbq.push_back(e);
    ifc.req_valid  = 1'b1;
    ifc.req_write  = w;
    ifc.req_funct3 = f3;
    ifc.req_addr   = a;
    ifc.req_wdata  = d;
    @(negedge clk);
    ifc.req_valid  = 1'b0;
    ifc.req_write  = 1'($urandom);
    ifc.req_funct3 = 3'($urandom);
    ifc.req_addr   = $urandom;
    ifc.req_wdata  = $urandom;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      if (sbq.size() == 0) done = 1'b1;
      else @(negedge clk);
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL %s.timeout: got no resp expected resp", nm);
      sbq.delete();
    end
  endtask

  int wr0;
  int nz0;
  bit seen;

  initial begin
    ifc.req_valid  = 1'b0;
    ifc.req_write  = 1'b0;
    ifc.req_funct3 = '0;
    ifc.req_addr   = '0;
    ifc.req_wdata  = '0;
    poke(6'd0, 32'h8011_2233);
    @(negedge clk);
    chk("rst.req_ready", {31'd0, ifc.req_ready}, 32'd1);
    chk("rst.resp_valid", {31'd0, ifc.resp_valid}, 32'd0);
    chk("rst.resp_rdata", ifc.resp_rdata, 32'd0);
    chk("rst.flags", {30'd0, ifc.resp_misaligned, ifc.resp_fault}, 32'd0);
    chk("rst.bus_address", ifc.bus_address, 32'd0);
    chk("rst.bus_wdata", ifc.bus_write_data, 32'd0);
    chk("rst.bus_wsig", {31'd0, ifc.bus_write_sig}, 32'd0);
    rst_n = 1'b1;

    access("lb", 0, F3_B, 32'h8000_0003, 0, 32'hFFFF_FF80, 0, 0, 2);
    chk("lb.bus_address", last_addr, 32'h8000_0000);
    access("lbu", 0, F3_BU, 32'h8000_0003, 0, 32'h0000_0080, 0, 0, 2);
    access("lb1", 0, F3_B, 32'h8000_0001, 0, 32'h0000_0022, 0, 0, 2);
    access("lh", 0, F3_H, 32'h8000_0002, 0, 32'hFFFF_8011, 0, 0, 2);
    access("lhu", 0, F3_HU, 32'h8000_0000, 0, 32'h0000_2233, 0, 0, 2);
    access("lw", 0, F3_W, 32'h8000_0000, 0, 32'h8011_2233, 0, 0, 2);

    poke(6'd0, 32'h1122_3344);
    wr0 = wr_count;
    access("sb", 1, F3_B, 32'h8000_0001, 32'hFFFF_FFAB, 0, 0, 0, 3);
    chk("sb.pulses", wr_count - wr0, 1);
    chk("sb.wdata", last_wdata, 32'h1122_AB44);
    access("lw_sb", 0, F3_W, 32'h8000_0000, 0, 32'h1122_AB44, 0, 0, 2);

    poke(6'd1, 32'h5566_7788);
    access("sh", 1, F3_H, 32'h8000_0006, 32'h1234_BEEF, 0, 0, 0, 3);
    chk("sh.mem", mem[1], 32'hBEEF_7788);

    wr0 = wr_count;
    nz0 = addr_nz;
    access("lh_mis", 0, F3_H, 32'h8000_0005, 0, 0, 1, 0, 1);
    access("sw_mis", 1, F3_W, 32'h8000_0002, 32'h1, 0, 1, 0, 1);
    access("lhu_mis", 0, F3_HU, 32'h8000_0003, 0, 0, 1, 0, 1);
    access("f3_011", 0, 3'b011, 32'h8000_0000, 0, 0, 0, 1, 1);
    access("st_f3_100", 1, 3'b100, 32'h8000_0000, 0, 0, 0, 1, 1);
    access("ill_mis", 0, 3'b011, 32'h8000_0001, 0, 0, 0, 1, 1);
    chk("mis.pulses", wr_count - wr0, 0);
    chk("mis.bus_addr", addr_nz - nz0, 0);

    access("lw_nosel", 0, F3_W, 32'h4000_0000, 0, 0, 0, 1, 2);
    access("sh_nosel", 1, F3_H, 32'h4000_0000, 32'h5, 0, 0, 1, 2);
    chk("nosel.pulses", wr_count - wr0, 0);

    access("sw", 1, F3_W, 32'h8000_0010, 32'hDEAD_BEEF, 0, 0, 0, SW_LAT);
    chk("sw.mem", mem[4], 32'hDEAD_BEEF);
    chk("sw.pulses", wr_count - wr0, 1);

    // Reset lands in the WR cycle of an SB; nothing may be written.
    wr0 = wr_count;
    @(negedge clk);
    ifc.req_valid  = 1'b1;
    ifc.req_write  = 1'b1;
    ifc.req_funct3 = F3_B;
    ifc.req_addr   = 32'h8000_0000;
    ifc.req_wdata  = 32'h77;
    @(negedge clk);
    ifc.req_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (ifc.bus_write_sig) seen = 1'b1;
      else @(negedge clk);
    end
    chk("rstwr.reached_wr", {31'd0, seen}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstwr.wsig", {31'd0, ifc.bus_write_sig}, 32'd0);
    chk("rstwr.resp", {31'd0, ifc.resp_valid}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rstwr.pulses", wr_count - wr0, 0);
    chk("rstwr.ready", {31'd0, ifc.req_ready}, 32'd1);
    chk("rstwr.mem", mem[0], 32'h1122_AB44);
    access("lw_after", 0, F3_W, 32'h8000_0000, 0, 32'h1122_AB44, 0, 0, 2);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_bus_master.md
Name: lsu_bus_master

Overview:
- Initiator side of the word-wide memory-mapped data bus. The bus responders (memory, MMIO devices) decode the address, answer reads combinationally, and capture word writes on clk.
- Sits between the execute stage and the bus. Turns RV32I LB/LH/LW/LBU/LHU/SB/SH/SW into word-aligned bus cycles.
- Sub-word stores are done by read-modify-write, because responders only accept full words.
- Each access is reported to the pipeline with one response pulse, carrying misalign and access-fault flags.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; only 32 is supported.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  pipeline presents an access.
- req_ready  out  1  LSU can accept an access; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 size/sign code.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_misaligned  out  1  misaligned access, no bus activity performed.
- resp_fault  out  1  no responder selected, or illegal funct3.
- bus_address  out  32  word-aligned bus address (bits [1:0] = 00).
- bus_write_data  out  32  write word.
- bus_write_sig  out  1  1 = write this cycle.
- bus_read_data  in  32  asynchronous read data from the responders.
- bus_selected  in  1  OR of all responder select lines.

Behaviour:
- Reset values:
  - state = IDLE; req_ready = 1.
  - resp_valid, resp_misaligned, resp_fault = 0; resp_rdata = 0.
  - bus_address, bus_write_data, bus_write_sig = 0.
  - All bus outputs are also 0 whenever the state is IDLE or RESP.
- States: IDLE, RD, WR, RESP.
- IDLE, on req_valid & req_ready: capture write, funct3, addr and wdata.
  - Illegal funct3 (011, 110, 111; also 100/101 for stores): go to RESP with fault = 1.
  - Misaligned (half with addr[0] = 1, or word with addr[1:0] != 00): go to RESP with misaligned = 1.
  - Otherwise go to RD.
  - A misaligned access with an illegal funct3 reports fault only.
- RD:
  - Drive bus_address = {addr[31:2], 00} and bus_write_sig = 0.
  - Register bus_read_data and bus_selected.
  - If !bus_selected: go to RESP with fault = 1 (a store skips WR).
  - Else a load goes to RESP and a store goes to WR.
- WR:
  - Drive the same address and bus_write_sig = 1 for exactly one cycle.
  - bus_write_data = merged word:
    - SB replaces byte addr[1:0] with wdata[7:0].
    - SH replaces half addr[1] with wdata[15:0].
    - SW uses wdata unchanged.
  - Then go to RESP.
- RESP:
  - resp_valid = 1 for one cycle, with the flags and rdata stable.
  - Then return to IDLE.
  - Back-to-back accesses are therefore spaced by at least one idle-accept cycle.
- Load extraction from the captured word:
  - LB sign-extends byte addr[1:0]; LBU zero-extends it.
  - LH sign-extends half addr[1]; LHU zero-extends it.
  - LW returns the word unchanged.
- Latency, counting the accept edge as cycle 0:
  - Load: resp_valid in cycle 2.
  - Store: resp_valid in cycle 3.
  - Misaligned or illegal: resp_valid in cycle 1.
- req_valid is ignored outside IDLE. The pipeline holds request fields only until the accept cycle.
- Reset asserted mid-operation: everything returns to reset values immediately. No write is completed and no response is issued.
- The bus has no wait states. Responders must answer reads in the same cycle.

Optional Feature:
- Macro: LSU_SW_FASTPATH_EN.
- Defined: an aligned SW skips RD and goes IDLE → WR → RESP, so resp_valid appears in cycle 2.
  - resp_fault is taken from bus_selected sampled in WR.
  - The write is still strobed even when no responder is selected; this is harmless.
- Undefined: SW goes through RD like other stores, with the read result unused and resp_valid in cycle 3.

Decomposition:
- Package lsu_pkg:
  - funct3 localparams F3_B = 000, F3_H = 001, F3_W = 010, F3_BU = 100, F3_HU = 101.
  - State encoding IDLE / RD / WR / RESP.
- Sub-module lsu_align, purely combinational:
  - Extract path: word, addr[1:0] and funct3 in, extended rdata out.
  - Merge path: old word, wdata, addr[1:0] and funct3 in, new word out.
  - Misalign check.
- The FSM, capture registers and bus drive stay in lsu_bus_master.

Test Plan:
- LB at 0x80000003, memory word 0x80112233 → bus_address 0x80000000, resp_rdata 0xFFFFFF80 in cycle 2. The same access with LBU → 0x00000080.
- SB 0xAB at 0x80000001 over word 0x11223344 → exactly one bus_write_sig pulse with 0x1122AB44, resp_valid in cycle 3. A follow-up LW reads 0x1122AB44.
- LH at 0x80000005 → resp_misaligned = 1 in cycle 1, bus_write_sig never asserted, bus_address stays 0.
- LW at 0x40000000 with bus_selected = 0 → resp_fault = 1 and resp_rdata = 0. The same address with SH → fault and no write pulse.
- SW 0xDEADBEEF at 0x80000010 → resp_valid in cycle 3 without the macro, cycle 2 with it; the memory word becomes 0xDEADBEEF in both cases.
- Assert rst_n low during WR of an SB → no write pulse, no resp_valid, req_ready = 1 after release.
